axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_mem_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI memory slave with a post-write snoop invalidate.
// First R beat READ_LATENCY cycles after AR; R, B and AC outputs hold while stalled.
module axi_mem_responder #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 13,
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awlock_i,
  input  logic [3:0]              awcache_i,
  input  logic [2:0]              awprot_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [7:0]              arlen_i,
  input  logic [2:0]              arsize_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arlock_i,
  input  logic [3:0]              arcache_i,
  input  logic [2:0]              arprot_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic                    acvalid_o,
  input  logic                    acready_i,
  output logic [ADDR_WIDTH-1:0]   acaddr_o,
  output logic [3:0]              acsnoop_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_WORDS);
  localparam int LINE  = $clog2(8 * BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = (ADDR_WIDTH'(1) << LINE) - ADDR_WIDTH'(1);
  localparam logic [15:0] WAIT_LAST = 16'(READ_LATENCY - 2);

  typedef enum logic [2:0] {IDLE, R_WAIT, R_DATA, W_DATA, W_RESP, SNOOP} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic [15:0]           wait_q, wait_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic                  last_beat;

  logic unused_ok;
  assign unused_ok = ^{awsize_i, awlock_i, awcache_i, awprot_i,
                       arsize_i, arlock_i, arcache_i, arprot_i};

  // WRAP keeps the upper index bits and wraps the low bits within the (len+1)-word block
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx,
                                               input logic [7:0] len,
                                               input logic [1:0] burst);
    logic [IDXW-1:0] mask;
    mask = IDXW'(len);
    case (burst)
      2'b00:   return idx;
      2'b10:   return (idx & ~mask) | ((idx + IDXW'(1)) & mask);
      default: return idx + IDXW'(1);
    endcase
  endfunction

  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    len_d     = len_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    err_d     = err_q;
    wait_d    = wait_q;
    awready_o = 1'b0;
    arready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    bid_o     = '0;
    bresp_o   = 2'b00;
    rvalid_o  = 1'b0;
    rid_o     = '0;
    rdata_o   = '0;
    rresp_o   = 2'b00;
    rlast_o   = 1'b0;
    acvalid_o = 1'b0;
    acaddr_o  = '0;
    acsnoop_o = 4'h0;
    case (state_q)
      IDLE: begin
        arready_o = 1'b1;
        // AW must not see a handshake while AR is winning arbitration
        awready_o = !arvalid_i;
        if (arvalid_i) begin
          id_d    = arid_i;
          addr_d  = araddr_i;
          idx_d   = araddr_i[OFF +: IDXW];
          len_d   = arlen_i;
          burst_d = arburst_i;
          beat_d  = '0;
          wait_d  = '0;
          state_d = (READ_LATENCY == 1) ? R_DATA : R_WAIT;
        end else if (awvalid_i) begin
          id_d    = awid_i;
          addr_d  = awaddr_i;
          idx_d   = awaddr_i[OFF +: IDXW];
          len_d   = awlen_i;
          burst_d = awburst_i;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = W_DATA;
        end
      end
      R_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = R_DATA;
        else                     wait_d  = wait_q + 16'd1;
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        rid_o    = id_q;
        rdata_o  = mem_q[idx_q];
        rresp_o  = (burst_q == 2'b11) ? 2'b10 : 2'b00;
        rlast_o  = last_beat;
        if (rready_i) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
            idx_d  = next_idx(idx_q, len_q, burst_q);
          end
        end
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          if (wlast_i != last_beat) err_d = 1'b1;
          if (last_beat) begin
            state_d = W_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
            idx_d  = next_idx(idx_q, len_q, burst_q);
          end
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        bid_o    = id_q;
        bresp_o  = (err_q || burst_q == 2'b11) ? 2'b10 : 2'b00;
        if (bready_i) state_d = SNOOP;
      end
      SNOOP: begin
        acvalid_o = 1'b1;
        acaddr_o  = addr_q & ~LINE_MASK;
        acsnoop_o = 4'hd;
        if (acready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are quiet for the whole time reset is held, not just after the first edge
    if (reset) begin
      awready_o = 1'b0;
      arready_o = 1'b0;
      wready_o  = 1'b0;
      bvalid_o  = 1'b0;
      bid_o     = '0;
      bresp_o   = 2'b00;
      rvalid_o  = 1'b0;
      rid_o     = '0;
      rdata_o   = '0;
      rresp_o   = 2'b00;
      rlast_o   = 1'b0;
      acvalid_o = 1'b0;
      acaddr_o  = '0;
      acsnoop_o = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // Storage is never cleared by reset; a beat presented during reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && state_q == W_DATA && wvalid_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_i[b]) mem_q[idx_q][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed plus randomized bursts against a word-array memory model.
module tb_axi_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] awid, arid, bid, rid;
  logic [63:0] awaddr, araddr, wdata, rdata, acaddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, acvalid, acready;
  logic [3:0]  acsnoop;

  int errors = 0;
  int checks = 0;
  int aw_in_read = 0;
  bit rd_active = 1'b0;
  logic [63:0] model_mem [1024];

  always #5 clk = ~clk;

  axi_mem_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(64), .ID_WIDTH(13), .MEM_WORDS(1024), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(3'd3), .awburst_i(awburst),
    .awlock_i(1'b0), .awcache_i(4'h0), .awprot_i(3'h0), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(3'd3), .arburst_i(arburst),
    .arlock_i(1'b0), .arcache_i(4'h0), .arprot_i(3'h0), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready),
    .acvalid_o(acvalid), .acready_i(acready), .acaddr_o(acaddr), .acsnoop_o(acsnoop)
  );

  always @(posedge clk) if (rd_active && awvalid && awready) aw_in_read++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [63:0] addr);
    return int'(addr[12:3]);
  endfunction

  // Word touched by beat k of a burst, from the burst rules alone
  function automatic int beat_word(input int start, input int len, input logic [1:0] burst, input int k);
    int n, base;
    n = len + 1;
    case (burst)
      2'b00:   return start;
      2'b10: begin
        base = start - (start % n);
        return base + ((start - base + k) % n);
      end
      default: return (start + k) % 1024;
    endcase
  endfunction

  task automatic do_write(input logic [63:0] addr, input logic [12:0] id, input int len,
                          input logic [1:0] burst, input logic [7:0] strb, input int wlast_at,
                          input bit seq_data, input bit aw_preset);
    int n, w, seen, hold;
    logic [63:0] d;
    logic [1:0] exp_resp;
    if (!aw_preset) begin
      @(negedge clk);
      awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
    end
    for (n = 0; n < 100; n++) begin #1; if (awready) break; @(negedge clk); end
    chk("aw_accept", 64'(n < 100), 64'd1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      d = seq_data ? 64'(k) : {$urandom, $urandom};
      wdata = d; wstrb = strb; wlast = (k == wlast_at); wvalid = 1'b1;
      for (n = 0; n < 100; n++) begin #1; if (wready) break; @(negedge clk); end
      chk("w_accept", 64'(n < 100), 64'd1);
      w = beat_word(word_of(addr), len, burst, k);
      for (int b = 0; b < 8; b++) if (strb[b]) model_mem[w][b*8 +: 8] = d[b*8 +: 8];
      @(posedge clk);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    exp_resp = ((wlast_at != len) || burst == 2'b11) ? 2'b10 : 2'b00;
    for (n = 0; n < 100; n++) begin #1; if (bvalid) break; @(negedge clk); end
    chk("b_seen", 64'(n < 100), 64'd1);
    chk("bid", 64'(bid), 64'(id));
    chk("bresp", 64'(bresp), 64'(exp_resp));
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0; acready = 1'b0; seen = 0; hold = $urandom_range(0, 2);
    for (n = 0; n < 100; n++) begin
      #1;
      if (acvalid) begin
        chk("acaddr", acaddr, addr & ~64'h3f);
        chk("acsnoop", 64'(acsnoop), 64'hd);
        if (acready) break;
        seen++;
      end
      @(negedge clk);
      acready = (seen > hold);
    end
    chk("ac_seen", 64'(n < 100), 64'd1);
    @(posedge clk);
    @(negedge clk);
    acready = 1'b0;
    #1;
    chk("idle_after_ac", 64'(arready), 64'd1);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] id, input int len,
                         input logic [1:0] burst, input bit rand_rdy, input int reset_at,
                         input bit also_aw);
    int n, lat, k, w;
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1; rready = 1'b0;
    if (also_aw) awvalid = 1'b1;
    for (n = 0; n < 100; n++) begin #1; if (arready) break; @(negedge clk); end
    chk("ar_accept", 64'(n < 100), 64'd1);
    if (also_aw) chk("ar_wins", 64'(n), 64'd0);
    @(posedge clk);
    for (lat = 1; lat < 100; lat++) begin
      @(negedge clk);
      arvalid = 1'b0;
      #1;
      if (rvalid) break;
    end
    chk("r_latency", 64'(lat), 64'(LAT));
    k = 0;
    for (n = 0; n < 400 && k <= len; n++) begin
      if (k == reset_at) begin
        reset = 1'b1; rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rvalid_after_reset", 64'(rvalid), 64'd0);
        reset = 1'b0;
        #1;
        chk("arready_after_reset", 64'(arready), 64'd1);
        chk("awready_after_reset", 64'(awready), 64'd1);
        return;
      end
      w = beat_word(word_of(addr), len, burst, k);
      chk("rvalid", 64'(rvalid), 64'd1);
      chk("rdata", rdata, model_mem[w]);
      chk("rid", 64'(rid), 64'(id));
      chk("rlast", 64'(rlast), 64'(k == len));
      chk("rresp", 64'(rresp), (burst == 2'b11) ? 64'd2 : 64'd0);
      rready = rand_rdy ? 1'($urandom % 2) : 1'b1;
      @(posedge clk);
      if (rready) k++;
      @(negedge clk);
      rready = 1'b0;
      #1;
    end
    chk("r_beats", 64'(k), 64'(len + 1));
    chk("rvalid_done", 64'(rvalid), 64'd0);
    chk("arready_done", 64'(arready), 64'd1);
  endtask

  initial begin
    logic [1:0]  b;
    logic [63:0] a;
    int          len, wd;
    reset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0; acready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_acvalid", 64'(acvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_acaddr", acaddr, 64'd0);
    chk("rst_acsnoop", 64'(acsnoop), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_arready", 64'(arready), 64'd1);
    chk("post_rst_awready", 64'(awready), 64'd1);

    // words 0..63 get known contents so every later read has a model value
    for (int i = 0; i < 4; i++) do_write(64'(i * 128), 13'($urandom), 15, 2'b01, 8'hff, 15, 1'b0, 1'b0);

    do_write(64'h40, 13'h1abc, 7, 2'b01, 8'hff, 7, 1'b1, 1'b0);
    do_read(64'h50, 13'h0123, 7, 2'b10, 1'b0, -1, 1'b0);

    do_read(64'h0, 13'h0777, 15, 2'b01, 1'b1, -1, 1'b0);
    do_read(64'h88, 13'h0042, 7, 2'b10, 1'b1, -1, 1'b0);

    do_write(64'h100, 13'h0055, 7, 2'b01, 8'h0f, 2, 1'b0, 1'b0);
    do_read(64'h100, 13'h0056, 7, 2'b01, 1'b1, -1, 1'b0);

    do_write(64'h180, 13'h0011, 3, 2'b00, 8'hf0, 3, 1'b0, 1'b0);
    do_read(64'h180, 13'h0012, 3, 2'b00, 1'b0, -1, 1'b0);

    do_write(64'h1c0, 13'h0099, 3, 2'b11, 8'hff, 3, 1'b0, 1'b0);
    do_read(64'h1c0, 13'h009a, 3, 2'b11, 1'b1, -1, 1'b0);

    // AR and AW raised together: read first, then the pending AW
    awid = 13'h0abc; awaddr = 64'h20; awlen = 8'd3; awburst = 2'b01;
    rd_active = 1'b1;
    do_read(64'h0, 13'h0bcd, 3, 2'b01, 1'b0, -1, 1'b1);
    rd_active = 1'b0;
    chk("aw_in_read", 64'(aw_in_read), 64'd0);
    do_write(64'h20, 13'h0abc, 3, 2'b01, 8'hff, 3, 1'b0, 1'b1);
    do_read(64'h20, 13'h0abd, 3, 2'b01, 1'b0, -1, 1'b0);

    do_read(64'h0, 13'h0321, 7, 2'b01, 1'b0, 2, 1'b0);
    do_read(64'h0, 13'h0322, 7, 2'b01, 1'b0, -1, 1'b0);

    for (int t = 0; t < 10; t++) begin
      b = ($urandom % 3 == 0) ? 2'b10 : (($urandom % 2 == 0) ? 2'b01 : 2'b00);
      len = (b == 2'b10) ? ((2 << $urandom_range(0, 3)) - 1) : $urandom_range(0, 15);
      wd = $urandom_range(0, 47);
      a = ({$urandom, $urandom} & ~64'h1fff) | 64'(wd << 3) | 64'($urandom_range(0, 7));
      if ($urandom % 2 == 0)
        do_write(a, 13'($urandom), len, b, 8'($urandom),
                 ($urandom % 4 == 0) ? $urandom_range(0, len) : len, 1'b0, 1'b0);
      else
        do_read(a, 13'($urandom), len, b, 1'b1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
